// File: rtl/stopwatch_counter.sv
// BCD stopwatch accumulator: prescaled +1 / +10 stepping driven by the control FSM's one-hot mode levels.
// Optional lap capture register is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_counter #(
   parameter int TICK_DIV   = 100,
   parameter int NUM_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    one_run_push,
   input  logic                    ten_run_push,
   input  logic                    pause_push,
   input  logic                    clear_push,
`ifdef STOPWATCH_LAP_EN
   input  logic                    lap,
   output logic [4*NUM_DIGITS-1:0] lap_digits,
`endif
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic                    tick,
   output logic                    wrap
);

   localparam int            PW       = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      MODE_HOLD,
      MODE_CLEAR,
      MODE_ONE,
      MODE_TEN
   } mode_t;

   mode_t                    mode;
   logic [PW-1:0]            pre;
   logic [4*NUM_DIGITS-1:0]  next_digits;
   logic                     carry_out;

   // Priority: clear > pause > ten > one; pause and idle both hold.
   always_comb begin
      mode = MODE_HOLD;
      if (clear_push)        mode = MODE_CLEAR;
      else if (pause_push)   mode = MODE_HOLD;
      else if (ten_run_push) mode = MODE_TEN;
      else if (one_run_push) mode = MODE_ONE;
   end

   // BCD ripple increment; in TEN mode the units digit is skipped so the carry enters digit 1.
   always_comb begin : bcd_inc
      logic carry;
      carry       = 1'b1;
      next_digits = digits;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (carry && !(i == 0 && mode == MODE_TEN)) begin
            if (digits[4*i +: 4] == 4'd9) begin
               next_digits[4*i +: 4] = 4'd0;
            end else begin
               next_digits[4*i +: 4] = digits[4*i +: 4] + 4'd1;
               carry                 = 1'b0;
            end
         end
      end
      carry_out = carry;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         digits <= '0;
         pre    <= '0;
         tick   <= 1'b0;
         wrap   <= 1'b0;
      end else begin
         tick <= 1'b0;
         wrap <= 1'b0;
         case (mode)
            MODE_CLEAR: begin
               digits <= '0;
               pre    <= '0;
            end
            MODE_ONE, MODE_TEN: begin
               if (pre == PRE_LAST) begin
                  pre    <= '0;
                  digits <= next_digits;
                  tick   <= 1'b1;
                  wrap   <= carry_out;
               end else begin
                  pre <= pre + PW'(1);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef STOPWATCH_LAP_EN
   // Captures the registered (pre-step) value; clear deliberately leaves the lap intact.
   always_ff @(posedge clk) begin
      if (rst)      lap_digits <= '0;
      else if (lap) lap_digits <= digits;
   end
`endif

endmodule
